// File: rtl/alarm_siren_ctrl.sv
// Alarm siren controller: entry-delay filter on A, timed siren, blinking strobe,
// latched indicator until DISARM, and a post-disarm hold-off before re-arming.
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   asynchronous, active-high reset
//   A       in   alarm request, sampled on clk
//   DISARM  in   user disarm, level-sensitive, synchronous
//   SIREN   out  siren drive (registered)
//   STROBE  out  visual strobe, blinks while latched (registered)
//   LATCHED out  alarm occurred and not yet disarmed (registered)
//   STATE   out  debug state: IDLE=0 PENDING=1 ALARM=2 TIMEOUT=3 HOLDOFF=4
module alarm_siren_ctrl #(
  parameter int ENTRY_CYC   = 8,
  parameter int SIREN_CYC   = 64,
  parameter int BLINK_CYC   = 4,
  parameter int HOLDOFF_CYC = 16,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       A,
  input  logic       DISARM,
  output logic       SIREN,
  output logic       STROBE,
  output logic       LATCHED,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PEND  = 3'd1,
    S_ALARM = 3'd2,
    S_TOUT  = 3'd3,
    S_HOLD  = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] ENTRY_LAST = CNT_W'(ENTRY_CYC - 1);
  localparam logic [CNT_W-1:0] SIREN_LAST = CNT_W'(SIREN_CYC - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYC - 1);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic             strobe_q, strobe_d;
  logic             siren_q, siren_d;
  logic             latched_q, latched_d;

  // Free-running blink step, used whenever the strobe keeps its phase.
  logic [CNT_W-1:0] bcnt_blk;
  logic             strobe_blk;

  always_comb begin
    if (bcnt_q == BLINK_LAST) begin
      bcnt_blk   = '0;
      strobe_blk = ~strobe_q;
    end else begin
      bcnt_blk   = bcnt_q + ONE;
      strobe_blk = strobe_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    ecnt_d   = ecnt_q;
    scnt_d   = scnt_q;
    bcnt_d   = bcnt_q;
    hcnt_d   = hcnt_q;
    strobe_d = strobe_q;

    if (DISARM) begin
      // Disarm wins over everything but reset, also restarting hold-off.
      state_d  = S_HOLD;
      ecnt_d   = '0;
      scnt_d   = '0;
      bcnt_d   = '0;
      hcnt_d   = '0;
      strobe_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (A) begin
            state_d = S_PEND;
            ecnt_d  = ONE;
          end
        end
        S_PEND: begin
          if (!A) begin
            state_d = S_IDLE;
            ecnt_d  = '0;
          end else if (ecnt_q == ENTRY_LAST) begin
            state_d  = S_ALARM;
            ecnt_d   = '0;
            scnt_d   = '0;
            bcnt_d   = '0;
            strobe_d = 1'b1;
          end else begin
            ecnt_d = ecnt_q + ONE;
          end
        end
        S_ALARM: begin
          // A is ignored here: the siren always runs its full time.
          bcnt_d   = bcnt_blk;
          strobe_d = strobe_blk;
          if (scnt_q == SIREN_LAST) begin
            state_d = S_TOUT;
            scnt_d  = '0;
          end else begin
            scnt_d = scnt_q + ONE;
          end
        end
        S_TOUT: begin
          if (A) begin
            // Re-trigger restarts siren time and strobe phase.
            state_d  = S_ALARM;
            scnt_d   = '0;
            bcnt_d   = '0;
            strobe_d = 1'b1;
          end else begin
            bcnt_d   = bcnt_blk;
            strobe_d = strobe_blk;
          end
        end
        S_HOLD: begin
          if (hcnt_q == HOLD_LAST) begin
            state_d = S_IDLE;
            hcnt_d  = '0;
          end else begin
            hcnt_d = hcnt_q + ONE;
          end
        end
        default: begin
          state_d  = S_IDLE;
          ecnt_d   = '0;
          scnt_d   = '0;
          bcnt_d   = '0;
          hcnt_d   = '0;
          strobe_d = 1'b0;
        end
      endcase
    end

    // Moore decode of the next state, so outputs come straight from flops.
    siren_d   = (state_d == S_ALARM);
    latched_d = (state_d == S_ALARM) || (state_d == S_TOUT);
    if (!latched_d) begin
      strobe_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ecnt_q    <= '0;
      scnt_q    <= '0;
      bcnt_q    <= '0;
      hcnt_q    <= '0;
      strobe_q  <= 1'b0;
      siren_q   <= 1'b0;
      latched_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ecnt_q    <= ecnt_d;
      scnt_q    <= scnt_d;
      bcnt_q    <= bcnt_d;
      hcnt_q    <= hcnt_d;
      strobe_q  <= strobe_d;
      siren_q   <= siren_d;
      latched_q <= latched_d;
    end
  end

  assign SIREN   = siren_q;
  assign STROBE  = strobe_q;
  assign LATCHED = latched_q;
  assign STATE   = state_q;

endmodule

// File: tb/tb_alarm_siren_ctrl.sv
// Testbench for alarm_siren_ctrl: vector table, corner sequences,
// and random stimulus against a timeline-based reference model.
module tb_alarm_siren_ctrl;

  localparam int ENTRY   = 8;
  localparam int SIREN_N = 64;
  localparam int BLINK   = 4;
  localparam int HOLD    = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a = 1'b0;
  logic       disarm = 1'b0;
  logic       siren, strobe, latched;
  logic [2:0] state;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alarm_siren_ctrl #(
    .ENTRY_CYC(ENTRY),
    .SIREN_CYC(SIREN_N),
    .BLINK_CYC(BLINK),
    .HOLDOFF_CYC(HOLD),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .A(a),
    .DISARM(disarm),
    .SIREN(siren),
    .STROBE(strobe),
    .LATCHED(latched),
    .STATE(state)
  );

  // Reference model: time since trigger / since disarm, run length of A.
  int m_n, m_run, m_trig, m_hstart;
  bit m_lat, m_hold;

  task automatic model_reset();
    m_n = 0; m_run = 0; m_trig = 0; m_hstart = 0;
    m_lat = 0; m_hold = 0;
  endtask

  task automatic model_edge(input logic ai, input logic di);
    m_n++;
    if (di) begin
      m_hold = 1; m_hstart = m_n; m_lat = 0; m_run = 0;
    end else if (m_hold) begin
      if (m_n - m_hstart >= HOLD) m_hold = 0;
    end else if (m_lat) begin
      if (ai && (m_n - 1 - m_trig) >= SIREN_N) m_trig = m_n;
    end else if (ai) begin
      m_run++;
      if (m_run == ENTRY) begin
        m_lat = 1; m_trig = m_n; m_run = 0;
      end
    end else begin
      m_run = 0;
    end
  endtask

  function automatic logic [5:0] model_exp();
    int el;
    logic s, st;
    logic [2:0] q;
    el = m_n - m_trig;
    s  = m_lat && (el < SIREN_N);
    st = m_lat && ((el / BLINK) % 2 == 0);
    if (m_hold) q = 3'd4;
    else if (m_lat) q = s ? 3'd2 : 3'd3;
    else if (m_run > 0) q = 3'd1;
    else q = 3'd0;
    return {s, st, m_lat, q};
  endfunction

  function automatic logic [5:0] outs();
    return {siren, strobe, latched, state};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input logic ai, input logic di);
    a = ai;
    disarm = di;
    @(posedge clk);
    model_edge(ai, di);
    #1;
    check("model", 32'(outs()), 32'(model_exp()));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a = 1'b0;
    disarm = 1'b0;
    @(posedge clk);
    #1;
    check("reset_state", 32'(outs()), 32'd0);
    reset = 1'b0;
    model_reset();
  endtask

  // Assert reset between edges and look before any clock edge.
  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", 32'(outs()), 32'd0);
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic       a;
    logic       d;
    int         n;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int cnt, tog;
    logic prev, lvl;

    // exp = {SIREN, STROBE, LATCHED, STATE}
    tbl[0]  = '{1'b1, 1'b0, 7,  6'b000001};
    tbl[1]  = '{1'b1, 1'b0, 1,  6'b111010};
    tbl[2]  = '{1'b0, 1'b0, 3,  6'b111010};
    tbl[3]  = '{1'b0, 1'b0, 4,  6'b101010};
    tbl[4]  = '{1'b0, 1'b0, 4,  6'b111010};
    tbl[5]  = '{1'b1, 1'b1, 1,  6'b000100};
    tbl[6]  = '{1'b1, 1'b0, 15, 6'b000100};
    tbl[7]  = '{1'b1, 1'b0, 1,  6'b000000};
    tbl[8]  = '{1'b1, 1'b0, 1,  6'b000001};
    tbl[9]  = '{1'b0, 1'b0, 1,  6'b000000};
    tbl[10] = '{1'b0, 1'b1, 1,  6'b000100};
    tbl[11] = '{1'b0, 1'b1, 3,  6'b000100};
    tbl[12] = '{1'b0, 1'b0, 15, 6'b000100};
    tbl[13] = '{1'b0, 1'b0, 1,  6'b000000};

    model_reset();
    do_reset();

    for (int i = 0; i < 14; i++) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        step(tbl[i].a, tbl[i].d);
        check($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
      end
    end

    // Short A bursts never raise the alarm.
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < ENTRY - 1; k++) step(1'b1, 1'b0);
      check("glitch_pend", 32'(state), 32'd1);
      step(1'b0, 1'b0);
      check("glitch_idle", 32'(state), 32'd0);
      check("glitch_siren", 32'(siren), 32'd0);
    end

    // Full siren duration, then TIMEOUT with strobe still blinking.
    for (int k = 0; k < ENTRY; k++) step(1'b1, 1'b0);
    check("trig_siren", 32'(siren), 32'd1);
    cnt = 1;
    for (int k = 0; k < 200; k++) begin
      step(1'b0, 1'b0);
      if (!siren) break;
      cnt++;
    end
    check("siren_len", 32'(cnt), 32'(SIREN_N));
    check("timeout_state", 32'(state), 32'd3);
    check("timeout_latched", 32'(latched), 32'd1);
    tog = 0;
    prev = strobe;
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 1'b0);
      if (strobe != prev) tog++;
      prev = strobe;
    end
    check("timeout_toggles", 32'(tog), 32'd4);

    // One-cycle A pulse re-triggers a full siren period.
    step(1'b1, 1'b0);
    check("retrig", 32'(outs()), 32'(6'b111010));
    cnt = 1;
    for (int k = 0; k < 200; k++) begin
      step(1'b0, 1'b0);
      if (!siren) break;
      cnt++;
    end
    check("retrig_len", 32'(cnt), 32'(SIREN_N));

    // Disarm mid-alarm with A held: hold-off, then normal entry delay.
    step(1'b1, 1'b0);
    check("alarm_again", 32'(state), 32'd2);
    step(1'b1, 1'b1);
    check("disarm_outs", 32'(outs()), 32'(6'b000100));
    cnt = 1;
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 1'b0);
      if (state != 3'd4) break;
      cnt++;
    end
    check("holdoff_len", 32'(cnt), 32'(HOLD));
    check("holdoff_exit", 32'(state), 32'd0);
    for (int k = 0; k < ENTRY - 1; k++) step(1'b1, 1'b0);
    check("rearm_pend", 32'(siren), 32'd0);
    step(1'b1, 1'b0);
    check("rearm_alarm", 32'(outs()), 32'(6'b111010));

    // Asynchronous reset while the siren is sounding.
    step(1'b0, 1'b0);
    async_reset();
    step(1'b0, 1'b0);
    check("post_reset", 32'(outs()), 32'd0);

    // Random stimulus: A as a slowly flipping level, rare disarm/reset.
    lvl = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 11) == 0) lvl = ~lvl;
      step(lvl, ($urandom_range(0, 149) == 0));
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
